// File: rtl/j80_host_writer_if.sv
// Byte-stream input and i8080 write-bus pins of the host writer.
// master: the byte source / bus observer side; slave: the j80_host_writer side.
interface j80_host_writer_if #(
    parameter int unsigned CNT_W = 16
);
    logic             in_valid;
    logic             in_rs;
    logic [7:0]       in_data;
    logic             in_ready;
    logic             J80_CLK;
    logic             J80_RS;
    logic             J80_We;
    logic [7:0]       J80_Data;
    logic             busy;
    logic [CNT_W-1:0] xfer_cnt;

    modport master (
        output in_valid,
        output in_rs,
        output in_data,
        input  in_ready,
        input  J80_CLK,
        input  J80_RS,
        input  J80_We,
        input  J80_Data,
        input  busy,
        input  xfer_cnt
    );

    modport slave (
        input  in_valid,
        input  in_rs,
        input  in_data,
        output in_ready,
        output J80_CLK,
        output J80_RS,
        output J80_We,
        output J80_Data,
        output busy,
        output xfer_cnt
    );
endinterface

// File: rtl/j80_host_writer.sv
// Host-side i8080 write engine: turns a valid/ready byte stream into
// strobed 8-bit write cycles. RS/data are loaded while the strobe is low
// and held through the rising edge, so the receiver always samples a
// settled bus. Every output is a register; in_ready is decoded from the
// registered next state, so it has no path from in_valid.
module j80_host_writer #(
    parameter int unsigned WR_LO    = 1,
    parameter int unsigned WR_HI    = 1,
    parameter int unsigned TAIL_CYC = 1,
    parameter int unsigned CNT_W    = 16
) (
    input logic               CLK,
    input logic               RST,
    j80_host_writer_if.slave  bus
);
    localparam int unsigned PH_MAX_LH = (WR_LO > WR_HI) ? WR_LO : WR_HI;
    localparam int unsigned PH_MAX    = (PH_MAX_LH > TAIL_CYC) ? PH_MAX_LH : TAIL_CYC;
    localparam int unsigned PH_W      = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOW  = 2'd1;
    localparam logic [1:0] HIGH = 2'd2;
    localparam logic [1:0] TAIL = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [PH_W-1:0]  ph_q, ph_d;
    logic             strobe_q, strobe_d;
    logic             we_q, we_d;
    logic             rs_q, rs_d;
    logic [7:0]       data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             accept_c;

    // Handshake completes only in states where the registered ready is high.
    assign accept_c = bus.in_valid & ready_q;

    // Next-state, phase counter and next output values.
    always_comb begin
        state_d  = state_q;
        ph_d     = ph_q;
        strobe_d = strobe_q;
        we_d     = we_q;
        rs_d     = rs_q;
        data_d   = data_q;
        cnt_d    = cnt_q;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    state_d  = LOW;
                    ph_d     = PH_W'(WR_LO - 1);
                    strobe_d = 1'b0;
                    we_d     = 1'b1;
                    rs_d     = bus.in_rs;
                    data_d   = bus.in_data;
                end
            end
            LOW: begin
                if (ph_q == '0) begin
                    state_d  = HIGH;
                    ph_d     = PH_W'(WR_HI - 1);
                    strobe_d = 1'b1;
                    cnt_d    = cnt_q + CNT_W'(1);
                end else begin
                    ph_d = ph_q - PH_W'(1);
                end
            end
            HIGH: begin
                if (ph_q == '0) begin
                    strobe_d = 1'b0;
                    if (accept_c) begin
                        state_d = LOW;
                        ph_d    = PH_W'(WR_LO - 1);
                        rs_d    = bus.in_rs;
                        data_d  = bus.in_data;
                    end else begin
                        state_d = TAIL;
                        ph_d    = PH_W'(TAIL_CYC - 1);
                    end
                end else begin
                    ph_d = ph_q - PH_W'(1);
                end
            end
            TAIL: begin
                if (accept_c) begin
                    state_d  = LOW;
                    ph_d     = PH_W'(WR_LO - 1);
                    strobe_d = 1'b0;
                    rs_d     = bus.in_rs;
                    data_d   = bus.in_data;
                end else if (ph_q == '0) begin
                    state_d = IDLE;
                    we_d    = 1'b0;
                end else begin
                    ph_d = ph_q - PH_W'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                strobe_d = 1'b0;
                we_d     = 1'b0;
            end
        endcase

        // Ready in IDLE, TAIL and the last HIGH cycle of a byte.
        ready_d = (state_d == IDLE) || (state_d == TAIL) ||
                  ((state_d == HIGH) && (ph_d == '0));
        busy_d  = (state_d != IDLE);
    end

    // State and output registers; reset drops the strobe and enable at once.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            ph_q     <= '0;
            strobe_q <= 1'b0;
            we_q     <= 1'b0;
            rs_q     <= 1'b0;
            data_q   <= '0;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ph_q     <= ph_d;
            strobe_q <= strobe_d;
            we_q     <= we_d;
            rs_q     <= rs_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.in_ready = ready_q;
    assign bus.J80_CLK  = strobe_q;
    assign bus.J80_RS   = rs_q;
    assign bus.J80_We   = we_q;
    assign bus.J80_Data = data_q;
    assign bus.busy     = busy_q;
    assign bus.xfer_cnt = cnt_q;
endmodule

// File: tb/tb_j80_host_writer.sv
// Bench for j80_host_writer: three parameterisations driven in turn, each
// cycle compared against a timing model derived from the accept times.
module tb_j80_host_writer;
    localparam int N = 3;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    j80_host_writer_if #(.CNT_W(16)) if0 ();
    j80_host_writer_if #(.CNT_W(4))  if1 ();
    j80_host_writer_if #(.CNT_W(16)) if2 ();

    j80_host_writer #(.WR_LO(1), .WR_HI(1), .TAIL_CYC(1), .CNT_W(16))
        u0 (.CLK(CLK), .RST(RST), .bus(if0));
    j80_host_writer #(.WR_LO(3), .WR_HI(2), .TAIL_CYC(4), .CNT_W(4))
        u1 (.CLK(CLK), .RST(RST), .bus(if1));
    j80_host_writer #(.WR_LO(4), .WR_HI(1), .TAIL_CYC(2), .CNT_W(16))
        u2 (.CLK(CLK), .RST(RST), .bus(if2));

    logic       iv   [N];
    logic       irs  [N];
    logic [7:0] idat [N];
    logic       o_ready [N];
    logic       o_clk   [N];
    logic       o_rs    [N];
    logic       o_we    [N];
    logic [7:0] o_data  [N];
    logic       o_busy  [N];
    logic [15:0] o_cnt  [N];

    assign if0.in_valid = iv[0]; assign if0.in_rs = irs[0]; assign if0.in_data = idat[0];
    assign if1.in_valid = iv[1]; assign if1.in_rs = irs[1]; assign if1.in_data = idat[1];
    assign if2.in_valid = iv[2]; assign if2.in_rs = irs[2]; assign if2.in_data = idat[2];

    assign o_ready[0] = if0.in_ready; assign o_clk[0] = if0.J80_CLK; assign o_rs[0] = if0.J80_RS;
    assign o_we[0] = if0.J80_We; assign o_data[0] = if0.J80_Data; assign o_busy[0] = if0.busy;
    assign o_cnt[0] = 16'(if0.xfer_cnt);
    assign o_ready[1] = if1.in_ready; assign o_clk[1] = if1.J80_CLK; assign o_rs[1] = if1.J80_RS;
    assign o_we[1] = if1.J80_We; assign o_data[1] = if1.J80_Data; assign o_busy[1] = if1.busy;
    assign o_cnt[1] = 16'(if1.xfer_cnt);
    assign o_ready[2] = if2.in_ready; assign o_clk[2] = if2.J80_CLK; assign o_rs[2] = if2.J80_RS;
    assign o_we[2] = if2.J80_We; assign o_data[2] = if2.J80_Data; assign o_busy[2] = if2.busy;
    assign o_cnt[2] = 16'(if2.xfer_cnt);

    // Timing parameters of each instance, as seen by the model.
    int lo [N];
    int hi [N];
    int tl [N];
    int cw [N];

    // Model state per instance: last accept time, bytes accepted, last byte.
    int         have  [N];
    int         alast [N];
    int         nacc  [N];
    logic       mrs   [N];
    logic [7:0] mdat  [N];
    logic       pclk  [N];
    int         wec   [N];
    int         cyc = 0;

    typedef struct {
        int         k;
        int         cyc;
        logic       rs;
        logic [7:0] data;
    } rx_t;
    rx_t rxq[$];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int k);
        have[k] = 0;
        alast[k] = 0;
        nacc[k] = 0;
        mrs[k] = 1'b0;
        mdat[k] = 8'h00;
    endtask

    // Expected pins follow from the cycles elapsed since the last accept.
    task automatic compare(input int k);
        int d;
        int per;
        int pend;
        int mask;
        logic e_we;
        logic e_clk;
        logic e_rdy;
        d = cyc - alast[k];
        per = lo[k] + hi[k];
        mask = (1 << cw[k]) - 1;
        if (RST) begin
            e_we = 1'b0; e_clk = 1'b0; e_rdy = 1'b0;
        end else if (have[k] == 0) begin
            e_we = 1'b0; e_clk = 1'b0; e_rdy = 1'b1;
        end else begin
            e_we  = (d < per + tl[k]);
            e_clk = (d >= lo[k]) && (d < per);
            e_rdy = (d >= per - 1);
        end
        pend = ((have[k] != 0) && (d < lo[k])) ? 1 : 0;
        chk($sformatf("u%0d.we@%0d", k, cyc),    32'(o_we[k]),    32'(e_we));
        chk($sformatf("u%0d.clk@%0d", k, cyc),   32'(o_clk[k]),   32'(e_clk));
        chk($sformatf("u%0d.busy@%0d", k, cyc),  32'(o_busy[k]),  32'(e_we));
        chk($sformatf("u%0d.ready@%0d", k, cyc), 32'(o_ready[k]), 32'(e_rdy));
        chk($sformatf("u%0d.rs@%0d", k, cyc),    32'(o_rs[k]),    32'(mrs[k]));
        chk($sformatf("u%0d.data@%0d", k, cyc),  32'(o_data[k]),  32'(mdat[k]));
        chk($sformatf("u%0d.cnt@%0d", k, cyc),   32'(o_cnt[k]),   32'((nacc[k] - pend) & mask));
    endtask

    // One clock: note handshakes before the edge, then sample and compare.
    task automatic step();
        logic       acc [N];
        logic       prs [N];
        logic [7:0] pd  [N];
        rx_t        r;
        for (int k = 0; k < N; k++) begin
            acc[k] = iv[k] && o_ready[k] && !RST;
            prs[k] = irs[k];
            pd[k]  = idat[k];
        end
        @(posedge CLK);
        #1;
        cyc++;
        for (int k = 0; k < N; k++) begin
            if (RST) begin
                model_reset(k);
            end else if (acc[k]) begin
                have[k] = 1;
                alast[k] = cyc;
                nacc[k]++;
                mrs[k] = prs[k];
                mdat[k] = pd[k];
            end
            if (o_clk[k] === 1'b1 && pclk[k] !== 1'b1) begin
                r.k = k; r.cyc = cyc; r.rs = o_rs[k]; r.data = o_data[k];
                rxq.push_back(r);
            end
            pclk[k] = o_clk[k];
            if (o_we[k] === 1'b1) wec[k]++;
            compare(k);
        end
    endtask

    task automatic send(input int k, input logic rs, input logic [7:0] d);
        logic got;
        got = 1'b0;
        iv[k] = 1'b1; irs[k] = rs; idat[k] = d;
        for (int i = 0; i < 40 && !got; i++) begin
            got = o_ready[k];
            step();
        end
        chk($sformatf("u%0d.accept", k), 32'(got), 32'd1);
    endtask

    task automatic wait_idle(input int k);
        iv[k] = 1'b0;
        for (int i = 0; i < 60 && o_busy[k] !== 1'b0; i++) step();
        chk($sformatf("u%0d.idle", k), 32'(o_busy[k]), 32'd0);
    endtask

    task automatic check_rx(input string tag, input int k, input int idx,
                            input logic rs, input logic [7:0] d);
        chk($sformatf("%s.k%0d", tag, idx),    32'(rxq[idx].k),    32'(k));
        chk($sformatf("%s.rs%0d", tag, idx),   32'(rxq[idx].rs),   32'(rs));
        chk($sformatf("%s.data%0d", tag, idx), 32'(rxq[idx].data), 32'(d));
    endtask

    logic [8:0] sent[$];
    int         w0;

    initial begin
        lo = '{1, 3, 4};
        hi = '{1, 2, 1};
        tl = '{1, 4, 2};
        cw = '{16, 4, 16};
        for (int k = 0; k < N; k++) begin
            iv[k] = 1'b0; irs[k] = 1'b0; idat[k] = 8'h00;
            pclk[k] = 1'b0; wec[k] = 0;
            model_reset(k);
        end

        // Reset held 5 cycles with in_valid toggling: everything stays at reset.
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < N; k++) begin
                iv[k] = i[0]; idat[k] = 8'($urandom);
            end
            step();
        end
        for (int k = 0; k < N; k++) iv[k] = 1'b0;
        chk("reset.no_strobe", 32'(rxq.size()), 32'd0);
        RST = 1'b0;
        step();
        for (int k = 0; k < N; k++) chk($sformatf("u%0d.ready_after_rst", k), 32'(o_ready[k]), 32'd1);

        // Single command with default timing.
        rxq.delete();
        w0 = wec[0];
        send(0, 1'b0, 8'h60);
        wait_idle(0);
        chk("single.nrx", 32'(rxq.size()), 32'd1);
        if (rxq.size() == 1) check_rx("single", 0, 0, 1'b0, 8'h60);
        chk("single.we_cycles", 32'(wec[0] - w0), 32'd3);
        chk("single.xfer", 32'(o_cnt[0]), 32'd1);

        // Back-to-back burst of 20 bytes, in_valid held high.
        rxq.delete();
        w0 = wec[0];
        for (int i = 0; i < 20; i++) send(0, 1'b0, 8'h60);
        wait_idle(0);
        chk("burst.nrx", 32'(rxq.size()), 32'd20);
        for (int i = 0; i < rxq.size(); i++) begin
            check_rx("burst", 0, i, 1'b0, 8'h60);
            if (i > 0) chk($sformatf("burst.period%0d", i), 32'(rxq[i].cyc - rxq[i-1].cyc), 32'd2);
        end
        chk("burst.we_cycles", 32'(wec[0] - w0), 32'd41);
        chk("burst.xfer", 32'(o_cnt[0]), 32'd21);

        // Mixed RS with WR_LO=3, WR_HI=2.
        rxq.delete();
        send(1, 1'b0, 8'h2C);
        send(1, 1'b1, 8'hAA);
        send(1, 1'b1, 8'h55);
        wait_idle(1);
        chk("mixed.nrx", 32'(rxq.size()), 32'd3);
        if (rxq.size() == 3) begin
            check_rx("mixed", 1, 0, 1'b0, 8'h2C);
            check_rx("mixed", 1, 1, 1'b1, 8'hAA);
            check_rx("mixed", 1, 2, 1'b1, 8'h55);
            chk("mixed.period1", 32'(rxq[1].cyc - rxq[0].cyc), 32'd5);
            chk("mixed.period2", 32'(rxq[2].cyc - rxq[1].cyc), 32'd5);
        end

        // Offers inside and beyond the TAIL window (TAIL_CYC=4).
        rxq.delete();
        send(1, 1'b0, 8'h11);
        iv[1] = 1'b0;
        repeat (5) step();
        chk("tail.fell", 32'(o_clk[1]), 32'd0);
        repeat (2) step();
        chk("tail.we_held", 32'(o_we[1]), 32'd1);
        send(1, 1'b1, 8'h22);
        iv[1] = 1'b0;
        repeat (5) step();
        repeat (6) step();
        chk("tail.we_dropped", 32'(o_we[1]), 32'd0);
        send(1, 1'b0, 8'h33);
        wait_idle(1);
        chk("tail.nrx", 32'(rxq.size()), 32'd3);
        if (rxq.size() == 3) begin
            check_rx("tail", 1, 0, 1'b0, 8'h11);
            check_rx("tail", 1, 1, 1'b1, 8'h22);
            check_rx("tail", 1, 2, 1'b0, 8'h33);
        end

        // Random bytes with random gaps on every instance.
        for (int k = 0; k < N; k++) begin
            int g;
            logic r;
            logic [7:0] d;
            rxq.delete();
            sent.delete();
            for (int i = 0; i < 30; i++) begin
                g = $urandom_range(0, 6);
                if (g > 0) begin
                    iv[k] = 1'b0;
                    repeat (g) step();
                end
                r = 1'($urandom);
                d = 8'($urandom);
                sent.push_back({r, d});
                send(k, r, d);
            end
            wait_idle(k);
            chk($sformatf("rand%0d.nrx", k), 32'(rxq.size()), 32'(sent.size()));
            for (int i = 0; i < rxq.size() && i < sent.size(); i++) begin
                check_rx($sformatf("rand%0d", k), k, i, sent[i][8], sent[i][7:0]);
            end
        end

        // Reset two cycles into LOW (WR_LO=4) abandons the byte.
        rxq.delete();
        send(2, 1'b1, 8'hC3);
        iv[2] = 1'b0;
        repeat (2) step();
        chk("midlow.in_low", 32'(o_clk[2]), 32'd0);
        RST = 1'b1;
        #1;
        for (int k = 0; k < N; k++) begin
            model_reset(k);
            compare(k);
        end
        repeat (2) step();
        RST = 1'b0;
        step();
        chk("midlow.no_strobe", 32'(rxq.size()), 32'd0);
        send(2, 1'b0, 8'h3C);
        wait_idle(2);
        chk("midlow.nrx", 32'(rxq.size()), 32'd1);
        if (rxq.size() == 1) check_rx("midlow", 2, 0, 1'b0, 8'h3C);
        chk("midlow.xfer", 32'(o_cnt[2]), 32'd1);

        // 17 bytes through a 4-bit counter wraps to 1.
        for (int i = 0; i < 17; i++) send(1, 1'(i), 8'(i * 7));
        wait_idle(1);
        chk("wrap.xfer", 32'(o_cnt[1]), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
